// File: rtl/alu_unit.sv
// Registered 16-function integer ALU with a sum-carry flag.
// One cycle of latency from A/B/ALU_sel to ALU_out/Carry_out.
module alu_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_sel,
   output logic [WIDTH-1:0] ALU_out,
   output logic             Carry_out
);

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;

   always_comb begin
      sum = {1'b0, A} + {1'b0, B};
      res = '0;
      unique case (ALU_sel)
         4'h0: res = sum[WIDTH-1:0];
         4'h1: res = A - B;
         4'h2: res = A * B;
         4'h3: res = (B == '0) ? '1 : A / B;
         4'h4: res = {A[WIDTH-2:0], 1'b0};
         4'h5: res = {1'b0, A[WIDTH-1:1]};
         4'h6: res = {A[WIDTH-2:0], A[WIDTH-1]};
         4'h7: res = {A[0], A[WIDTH-1:1]};
         4'h8: res = A & B;
         4'h9: res = A | B;
         4'hA: res = A ^ B;
         4'hB: res = ~(A | B);
         4'hC: res = ~(A & B);
         4'hD: res = ~(A ^ B);
         4'hE: res = {{(WIDTH-1){1'b0}}, A > B};
         4'hF: res = {{(WIDTH-1){1'b0}}, A == B};
      endcase
   end

   // Carry is the add carry regardless of the selected function.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ALU_out   <= '0;
         Carry_out <= 1'b0;
      end else begin
         ALU_out   <= res;
         Carry_out <= sum[WIDTH];
      end
   end

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit (WIDTH=8).
// Expected results are queued on drive and popped one edge later.
module tb_alu_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [3:0] sel = '0;
   logic [7:0] alu_out;
   logic       carry_out;

   logic [8:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   alu_unit #(.WIDTH(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .A(a),
      .B(b),
      .ALU_sel(sel),
      .ALU_out(alu_out),
      .Carry_out(carry_out)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] model(input logic [7:0] x,
                                        input logic [7:0] y,
                                        input logic [3:0] s);
      int         sm;
      logic [7:0] r;
      sm = int'(x) + int'(y);
      r = 8'h00;
      case (s)
         4'h0: r = 8'(sm % 256);
         4'h1: r = 8'((int'(x) - int'(y) + 256) % 256);
         4'h2: r = 8'((int'(x) * int'(y)) % 256);
         4'h3: r = (y == 8'h00) ? 8'hFF : 8'(int'(x) / int'(y));
         4'h4: r = 8'((int'(x) * 2) % 256);
         4'h5: r = 8'(int'(x) / 2);
         4'h6: r = 8'(((int'(x) * 2) % 256) + int'(x) / 128);
         4'h7: r = 8'(int'(x) / 2 + (int'(x) % 2) * 128);
         4'h8: r = x & y;
         4'h9: r = x | y;
         4'hA: r = x ^ y;
         4'hB: r = ~(x | y);
         4'hC: r = ~(x & y);
         4'hD: r = ~(x ^ y);
         4'hE: r = (x > y) ? 8'd1 : 8'd0;
         4'hF: r = (x == y) ? 8'd1 : 8'd0;
      endcase
      return {(sm > 255), r};
   endfunction

   task automatic drive(input logic [7:0] x, input logic [7:0] y,
                        input logic [3:0] s);
      @(negedge clk);
      a = x;
      b = y;
      sel = s;
      exp_q.push_back(model(x, y, s));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({carry_out, alu_out} !== 9'h000) begin
         errors++;
         $display("FAIL reset_init got %h want 000", {carry_out, alu_out});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_arith();
      logic [23:0] tbl[4] = '{24'h0FF_01_0, 24'h012_34_0,
                              24'h005_07_1, 24'h080_80_1};
      logic [8:0]  want[4] = '{9'h100, 9'h046, 9'h0FE, 9'h100};
      for (int i = 0; i < 4; i++) begin
         logic [8:0] e;
         drive(tbl[i][19:12], tbl[i][11:4], tbl[i][3:0]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({carry_out, alu_out} !== e || e !== want[i]) begin
            errors++;
            $display("FAIL arith%0d got %h want %h", i,
                     {carry_out, alu_out}, want[i]);
         end
      end
   endtask

   task automatic test_muldiv();
      logic [23:0] tbl[4] = '{24'h010_11_2, 24'h064_07_3,
                              24'h064_00_3, 24'h0FF_10_2};
      logic [7:0]  want[4] = '{8'h10, 8'h0E, 8'hFF, 8'hF0};
      for (int i = 0; i < 4; i++) begin
         logic [8:0] e;
         drive(tbl[i][19:12], tbl[i][11:4], tbl[i][3:0]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({carry_out, alu_out} !== e || alu_out !== want[i]) begin
            errors++;
            $display("FAIL muldiv%0d got %h want %h", i,
                     {carry_out, alu_out}, e);
         end
      end
   endtask

   task automatic test_shift();
      logic [7:0] want[4] = '{8'h02, 8'h40, 8'h03, 8'hC0};
      for (int i = 0; i < 4; i++) begin
         logic [8:0] e;
         drive(8'h81, 8'hA5, 4'(4 + i));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({carry_out, alu_out} !== e || alu_out !== want[i]) begin
            errors++;
            $display("FAIL shift%0d got %h want %h", i,
                     {carry_out, alu_out}, e);
         end
      end
   endtask

   task automatic test_logic();
      logic [7:0] want[8] = '{8'h30, 8'hFC, 8'hCC, 8'h03,
                              8'hCF, 8'h33, 8'h01, 8'h01};
      for (int i = 0; i < 8; i++) begin
         logic [8:0] e;
         if (i == 7) drive(8'h3C, 8'h3C, 4'hF);
         else drive(8'hF0, 8'h3C, 4'(8 + i));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({carry_out, alu_out} !== e || alu_out !== want[i]) begin
            errors++;
            $display("FAIL logic%0d got %h want %h", i,
                     {carry_out, alu_out}, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 48; i++) begin
         logic [8:0] e;
         drive(8'($urandom_range(255)), 8'($urandom_range(255)),
               4'(i % 16));
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) e = 9'h1FF;
         else e = exp_q.pop_front();
         checks++;
         if ({carry_out, alu_out} !== e) begin
            errors++;
            $display("FAIL b2b%0d sel=%h got %h want %h", i, sel,
                     {carry_out, alu_out}, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [8:0] e;
      drive(8'hFF, 8'h5B, 4'h0);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({carry_out, alu_out} !== e || e !== 9'h15A) begin
         errors++;
         $display("FAIL pre_reset got %h want 15a", {carry_out, alu_out});
      end
      drive(8'h12, 8'h34, 4'h0);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      checks++;
      if ({carry_out, alu_out} !== 9'h000) begin
         errors++;
         $display("FAIL async_reset got %h want 000", {carry_out, alu_out});
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({carry_out, alu_out} !== 9'h000) begin
            errors++;
            $display("FAIL reset_hold%0d got %h want 000", i,
                     {carry_out, alu_out});
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(8'h80, 8'h81, 4'h0);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({carry_out, alu_out} !== e || e !== 9'h101) begin
         errors++;
         $display("FAIL post_reset got %h want 101", {carry_out, alu_out});
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_muldiv();
      test_shift();
      test_logic();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
